term_writer: RTL and testbench
==============================

TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 SHALL have parameter COLS, default 60, visible columns per row (1..64).
REQ-002 SHALL have parameter ROWS, default 17, visible rows (1..32).
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, full-buffer clear after reset when 1.
REQ-004 SHALL have port i_clk, input, 1, single clock (pixel clock domain).
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_data, input, 8, received byte.
REQ-007 SHALL have port i_valid, input, 1, i_data valid.
REQ-008 SHALL have port o_ready, output, 1, byte accepted when i_valid and o_ready are both high.
REQ-009 SHALL have port o_address, output, 11, character buffer write address {row[4:0], col[5:0]}.
REQ-010 SHALL have port o_data, output, 8, character code to write.
REQ-011 SHALL have port o_we, output, 1, write strobe, one cycle per write.
REQ-012 SHALL have ports o_cur_x (6 bits) and o_cur_y (5 bits), outputs, current cursor column and row.
REQ-013 SHALL use one clock only; reset SHALL be synchronous and active-high.

Function
REQ-014 SHALL implement states IDLE, CLR_LINE and CLR_SCREEN; o_ready SHALL be high only in IDLE.
REQ-015 On acceptance of a printable byte (0x20..0x7E or 0x80..0xFF), the next cycle SHALL set o_we=1, o_data=byte and o_address={cur_y,cur_x}, then advance cur_x.
REQ-016 Write at cur_x=COLS-1 SHALL wrap: cur_x=0, then perform a line feed per REQ-018.
REQ-017 0x0D (CR) SHALL set cur_x=0 with no write.
REQ-018 0x0A (LF) SHALL set cur_y=cur_y+1, or 0 when cur_y=ROWS-1, then enter CLR_LINE for the new row.
REQ-019 CLR_LINE SHALL write 0x20 to cols 0..63 of cur_y, one per cycle (64 cycles), then return to IDLE.
REQ-020 0x08 (BS) with cur_x>0 SHALL decrement cur_x and write 0x20 at the new position; with cur_x=0 it SHALL do nothing.
REQ-021 0x09 (TAB) SHALL advance cur_x to the next multiple of 8, saturating at COLS-1, with no write.
REQ-022 0x0C (FF) SHALL enter CLR_SCREEN: write 0x20 to addresses 0..2047 ascending, one per cycle, then home the cursor to (0,0) and return to IDLE.
REQ-023 Other bytes (0x00..0x1F not listed above, and 0x7F) SHALL be consumed silently.
REQ-024 i_valid while o_ready is low SHALL NOT be consumed; the upstream source SHALL hold the byte.
REQ-025 o_we SHALL be low in every cycle without a write; a clear sequence SHALL NOT skip or repeat addresses.
REQ-026 Worst-case service time SHALL be 2049 cycles (FF) and 65 cycles (LF/wrap).

Reset
REQ-027 i_rst SHALL force o_we=0, o_data=0, o_address=0, cursor (0,0) and o_ready=0.
REQ-028 After reset, the block SHALL enter CLR_SCREEN if CLEAR_ON_RESET=1, otherwise IDLE.
REQ-029 Reset during a clear sequence SHALL abort it and restart per REQ-028.

Structure
REQ-030 Package term_pkg SHALL hold the control codes (CR, LF, BS, TAB, FF, SPACE), the state encoding, and the buffer geometry constants 64x32 and the address width 11.
REQ-031 Cursor arithmetic (advance, wrap, tab, backspace) SHALL live in one sub-module, term_cursor; the clear sequencer and write port SHALL stay in term_writer.

Verification
REQ-032 Reset with CLEAR_ON_RESET=1 -> 2048 consecutive o_we pulses, o_data=0x20, addresses 0..2047, then o_ready=1 and cursor (0,0).
REQ-033 Send "AB" -> writes 0x41@0x000 and 0x42@0x001 one cycle after each acceptance, then cursor (2,0).
REQ-034 Write 60 printable bytes on row 0 -> 60th write @0x03B, then cursor (0,1) and 64 space writes @0x040..0x07F.
REQ-035 With cursor (5,16), send LF -> cur_y=0 and clear of 0x000..0x03F; with cursor (5,3), send CR -> (0,3) and no write.
REQ-036 TAB at x=57 -> x=59; BS at x=0 -> no write; BS at x=3 -> write 0x20@{y,2}, x=2.
REQ-037 Hold i_valid high during an FF clear -> o_ready stays low for 2048 cycles and the byte is accepted exactly once afterward.

Source files
------------

// File: rtl/term_pkg.sv
// Shared definitions for the terminal character-buffer writer: control codes,
// buffer geometry, FSM state encoding and cursor operation codes.
package term_pkg;

  // Physical character buffer is always 64 columns x 32 rows.
  localparam int BUF_COLS = 64;
  localparam int BUF_ROWS = 32;
  localparam int COL_W    = $clog2(BUF_COLS);
  localparam int ROW_W    = $clog2(BUF_ROWS);
  localparam int ADDR_W   = COL_W + ROW_W;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_PRINT,
    CUR_CR,
    CUR_LF,
    CUR_BS,
    CUR_TAB,
    CUR_HOME
  } cursor_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || b[7];
  endfunction

endpackage

// File: rtl/term_cursor.sv
// Cursor position register and all cursor arithmetic: printable advance with
// end-of-line wrap, carriage return, line feed, backspace, tab stops and home.
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS = 60,
  parameter int ROWS = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_op,
  output logic [COL_W-1:0] o_cur_x,
  output logic [ROW_W-1:0] o_cur_y,
  output logic             o_at_eol,
  output logic             o_can_bs,
  output logic [COL_W-1:0] o_bs_x
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  cursor_op_t       op;
  logic [COL_W-1:0] x_d;
  logic [ROW_W-1:0] y_d;
  logic [ROW_W-1:0] y_inc;
  logic [COL_W:0]   tab_stop;
  logic [COL_W-1:0] tab_x;

  assign op       = cursor_op_t'(i_op);
  assign o_at_eol = (o_cur_x == LAST_COL);
  assign o_can_bs = |o_cur_x;
  assign o_bs_x   = o_cur_x - COL_W'(1);

  // Row advance wraps from the last visible row back to the top.
  assign y_inc = (o_cur_y == LAST_ROW) ? '0 : o_cur_y + ROW_W'(1);

  // Next multiple of 8, computed one bit wider so the stop past column 63
  // is still visible to the saturation compare.
  assign tab_stop = {1'b0, o_cur_x[COL_W-1:3], 3'b000} + (COL_W + 1)'(8);
  assign tab_x    = (tab_stop >= {1'b0, LAST_COL}) ? LAST_COL : tab_stop[COL_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    x_d = o_cur_x;
    y_d = o_cur_y;
    case (op)
      CUR_PRINT: begin
        if (o_at_eol) begin
          x_d = '0;
          y_d = y_inc;
        end else begin
          x_d = o_cur_x + COL_W'(1);
        end
      end
      CUR_CR:   x_d = '0;
      CUR_LF:   y_d = y_inc;
      CUR_BS:   if (o_can_bs) x_d = o_bs_x;
      CUR_TAB:  x_d = tab_x;
      CUR_HOME: begin
        x_d = '0;
        y_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      o_cur_x <= '0;
      o_cur_y <= '0;
    end else begin
      o_cur_x <= x_d;
      o_cur_y <= y_d;
    end
  end

endmodule

// File: rtl/term_writer.sv
// Byte-stream to character-buffer writer: decodes received bytes, drives the
// buffer write port and sequences line and full-screen clears.
module term_writer
  import term_pkg::*;
#(
  parameter int COLS           = 60,
  parameter int ROWS           = 17,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_address,
  output logic [7:0]        o_data,
  output logic              o_we,
  output logic [COL_W-1:0]  o_cur_x,
  output logic [ROW_W-1:0]  o_cur_y
);

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLR_SCREEN : ST_IDLE;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic              we_d;
  logic [7:0]        data_d;
  logic [ADDR_W-1:0] addr_d;
  cursor_op_t        cur_op;
  logic              accept;
  logic              at_eol;
  logic              can_bs;
  logic [COL_W-1:0]  bs_x;

  term_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_op     (cur_op),
    .o_cur_x  (o_cur_x),
    .o_cur_y  (o_cur_y),
    .o_at_eol (at_eol),
    .o_can_bs (can_bs),
    .o_bs_x   (bs_x)
  );

  assign o_ready = (state == ST_IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;

  always_comb begin
    next_state = state;
    clr_cnt_d  = clr_cnt;
    we_d       = 1'b0;
    data_d     = o_data;
    addr_d     = o_address;
    cur_op     = CUR_NONE;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(i_data)) begin
            we_d   = 1'b1;
            data_d = i_data;
            addr_d = {o_cur_y, o_cur_x};
            cur_op = CUR_PRINT;
            // The wrapping write also moves to a fresh row, which must be blanked.
            if (at_eol) begin
              next_state = ST_CLR_LINE;
              clr_cnt_d  = '0;
            end
          end else begin
            case (i_data)
              CH_CR:  cur_op = CUR_CR;
              CH_TAB: cur_op = CUR_TAB;
              CH_LF: begin
                cur_op     = CUR_LF;
                next_state = ST_CLR_LINE;
                clr_cnt_d  = '0;
              end
              CH_BS: begin
                if (can_bs) begin
                  we_d   = 1'b1;
                  data_d = CH_SPACE;
                  addr_d = {o_cur_y, bs_x};
                  cur_op = CUR_BS;
                end
              end
              CH_FF: begin
                next_state = ST_CLR_SCREEN;
                clr_cnt_d  = '0;
              end
              default: ;
            endcase
          end
        end
      end

      // Blanks all 64 physical columns of the cursor row, including the
      // invisible ones beyond COLS.
      ST_CLR_LINE: begin
        we_d      = 1'b1;
        data_d    = CH_SPACE;
        addr_d    = {o_cur_y, clr_cnt[COL_W-1:0]};
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt[COL_W-1:0] == '1) begin
          next_state = ST_IDLE;
        end
      end

      ST_CLR_SCREEN: begin
        we_d      = 1'b1;
        data_d    = CH_SPACE;
        addr_d    = clr_cnt;
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) begin
          next_state = ST_IDLE;
          cur_op     = CUR_HOME;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      o_we      <= 1'b0;
      o_data    <= '0;
      o_address <= '0;
    end else begin
      state     <= next_state;
      clr_cnt   <= clr_cnt_d;
      o_we      <= we_d;
      o_data    <= data_d;
      o_address <= addr_d;
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Self-checking bench for term_writer: directed scenarios plus random bytes,
// compared against a behavioural screen model with per-write timestamps.
module tb_term_writer;

  localparam int COLS  = 60;
  localparam int ROWS  = 17;
  localparam int LIMIT = 3000;

  typedef struct {
    int stamp;
    int addr;
    int data;
  } wr_t;

  logic        i_clk   = 1'b0;
  logic        i_rst   = 1'b1;
  logic [7:0]  i_data  = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [10:0] o_address;
  logic [7:0]  o_data;
  logic        o_we;
  logic [5:0]  o_cur_x;
  logic [4:0]  o_cur_y;

  int  cyc      = 0;
  int  n_assert = 0;
  int  n_fail   = 0;
  int  mx       = 0;
  int  my       = 0;
  wr_t wq[$];
  wr_t exp_q[$];

  term_writer #(
    .COLS           (COLS),
    .ROWS           (ROWS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_address (o_address),
    .o_data    (o_data),
    .o_we      (o_we),
    .o_cur_x   (o_cur_x),
    .o_cur_y   (o_cur_y)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Every write strobe is logged with the number of edges seen so far.
  always @(negedge i_clk) begin
    if (o_we === 1'b1) wq.push_back(wr_t'{cyc, int'(o_address), int'(o_data)});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void push_exp(input int t, input int a, input int d);
    exp_q.push_back(wr_t'{t, a, d});
  endfunction

  function automatic void model_line_feed(input int start);
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int c = 0; c < 64; c++) push_exp(start + c, my * 64 + c, 'h20);
  endfunction

  // Screen model: queues the expected writes for one accepted byte and
  // returns how many cycles the writer stays busy afterwards.
  function automatic int model_byte(input int b, input int acc);
    int busy;
    busy = 0;
    if ((b >= 'h20 && b <= 'h7E) || b >= 'h80) begin
      push_exp(acc, my * 64 + mx, b);
      if (mx == COLS - 1) begin
        mx = 0;
        model_line_feed(acc + 1);
        busy = 64;
      end else begin
        mx++;
      end
    end else if (b == 'h0D) begin
      mx = 0;
    end else if (b == 'h0A) begin
      model_line_feed(acc + 1);
      busy = 64;
    end else if (b == 'h08) begin
      if (mx > 0) begin
        mx--;
        push_exp(acc, my * 64 + mx, 'h20);
      end
    end else if (b == 'h09) begin
      mx = (mx / 8 + 1) * 8;
      if (mx > COLS - 1) mx = COLS - 1;
    end else if (b == 'h0C) begin
      for (int a = 0; a < 2048; a++) push_exp(acc + 1 + a, a, 'h20);
      mx   = 0;
      my   = 0;
      busy = 2048;
    end
    return busy;
  endfunction

  task automatic send(input logic [7:0] b, output int acc, output int waited);
    i_data  = b;
    i_valid = 1'b1;
    waited  = 0;
    while (o_ready !== 1'b1 && waited < LIMIT) begin
      step();
      waited++;
    end
    check("accept_ready", 32'(o_ready), 1);
    acc = cyc + 1;
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int busy);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_busy"}, n, busy);
  endtask

  task automatic drain(input string tag);
    int bad;
    int nw;
    int ne;
    bad = -1;
    nw  = wq.size();
    ne  = exp_q.size();
    check({tag, "_nwrites"}, nw, ne);
    for (int i = 0; i < nw && i < ne; i++) begin
      if (bad < 0 && (wq[i].stamp != exp_q[i].stamp || wq[i].addr != exp_q[i].addr ||
                      wq[i].data != exp_q[i].data)) bad = i;
    end
    n_assert++;
    assert (bad < 0) else begin
      n_fail++;
      $error("FAIL %s_writes: entry %0d observed t=%0d addr=%0h data=%0h expected t=%0d addr=%0h data=%0h",
             tag, bad, wq[bad].stamp, wq[bad].addr, wq[bad].data,
             exp_q[bad].stamp, exp_q[bad].addr, exp_q[bad].data);
    end
    wq.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, 32'(o_cur_x), mx);
    check({tag, "_y"}, 32'(o_cur_y), my);
  endtask

  task automatic put(input logic [7:0] b, input string tag);
    int acc;
    int w;
    int busy;
    send(b, acc, w);
    busy = model_byte(int'(b), acc);
    wait_idle(tag, busy);
    drain(tag);
    check_cursor(tag);
  endtask

  task automatic do_reset(input string tag);
    int base;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    step();
    step();
    check({tag, "_rst_we"},    32'(o_we), 0);
    check({tag, "_rst_data"},  32'(o_data), 0);
    check({tag, "_rst_addr"},  32'(o_address), 0);
    check({tag, "_rst_x"},     32'(o_cur_x), 0);
    check({tag, "_rst_y"},     32'(o_cur_y), 0);
    check({tag, "_rst_ready"}, 32'(o_ready), 0);
    wq.delete();
    exp_q.delete();
    mx   = 0;
    my   = 0;
    base = cyc;
    for (int a = 0; a < 2048; a++) push_exp(base + 1 + a, a, 'h20);
    i_rst = 1'b0;
    wait_idle(tag, 2048);
    drain(tag);
    check_cursor(tag);
  endtask

  initial begin
    int acc1;
    int acc2;
    int w;
    int b1;
    int b2;
    int r;
    logic [7:0] rb;

    // Power-on clear of the whole buffer.
    do_reset("por");

    put(8'h41, "char_a");
    put(8'h42, "char_b");
    check("ab_x", 32'(o_cur_x), 2);
    check("ab_y", 32'(o_cur_y), 0);

    // Fill row 0; the 60th byte wraps and blanks row 1.
    put(CR_BYTE(), "cr0");
    for (int i = 0; i < COLS; i++) put(8'(8'h30 + (i % 10)), "row0");
    check("wrap_x", 32'(o_cur_x), 0);
    check("wrap_y", 32'(o_cur_y), 1);

    // Line feed from the last visible row wraps to the top.
    for (int i = 0; i < 15; i++) put(8'h0A, "lf_down");
    put(8'h0D, "cr16");
    for (int i = 0; i < 5; i++) put(8'h78, "x16");
    check("pos16_y", 32'(o_cur_y), 16);
    put(8'h0A, "lf_last");
    check("lf_last_y", 32'(o_cur_y), 0);
    check("lf_last_x", 32'(o_cur_x), 5);
    for (int i = 0; i < 3; i++) put(8'h0A, "lf_3");
    put(8'h0D, "cr3");
    check("cr3_x", 32'(o_cur_x), 0);
    check("cr3_y", 32'(o_cur_y), 3);

    // Backspace at column 0 and at column 3.
    put(8'h08, "bs0");
    check("bs0_x", 32'(o_cur_x), 0);
    put(8'h61, "abc");
    put(8'h62, "abc");
    put(8'h63, "abc");
    put(8'h08, "bs3");
    check("bs3_x", 32'(o_cur_x), 2);

    // Tab stops and saturation at the last visible column.
    put(8'h0D, "cr_tab");
    for (int i = 0; i < 7; i++) put(8'h09, "tab");
    check("tab56_x", 32'(o_cur_x), 56);
    put(8'h7A, "z57");
    put(8'h09, "tab57");
    check("tab57_x", 32'(o_cur_x), 59);
    put(8'h09, "tab59");
    check("tab59_x", 32'(o_cur_x), 59);

    // Ignored control codes.
    put(8'h7F, "del");
    put(8'h00, "nul");
    put(8'h1B, "esc");

    // A byte held during a full-screen clear is accepted exactly once after it.
    send(8'h0C, acc1, w);
    b1 = model_byte('h0C, acc1);
    send(8'h58, acc2, w);
    check("ff_hold_wait", w, b1);
    b2 = model_byte('h58, acc2);
    wait_idle("ff_hold", b2);
    drain("ff_hold");
    check_cursor("ff_hold");

    // Reset in the middle of a clear restarts the clear from address 0.
    put(8'h51, "pre_abort");
    send(8'h0C, acc1, w);
    for (int i = 0; i < 300; i++) step();
    do_reset("abort");

    // Random traffic without form feeds.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if ($urandom_range(0, 1) == 1) rb = 8'($urandom_range(32, 126));
        else rb = 8'($urandom_range(128, 255));
      end else if (r == 5) rb = 8'h0D;
      else if (r == 6) rb = 8'h0A;
      else if (r == 7) rb = 8'h08;
      else if (r == 8) rb = 8'h09;
      else begin
        case ($urandom_range(0, 3))
          0: rb = 8'h00;
          1: rb = 8'h01;
          2: rb = 8'h1B;
          default: rb = 8'h7F;
        endcase
      end
      put(rb, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  function automatic logic [7:0] CR_BYTE();
    return 8'h0D;
  endfunction

endmodule
